onion_wb_initiator: RTL

Wishbone initiator that turns single register-access commands into Wishbone bus cycles toward the FPGA IP slave fabric (GPIO, PWM, breathe, timer and QL-reserved apertures). It sits upstream of the aperture decoder and drives the same address, cycle, strobe, byte-enable, write/read and data signals the slaves consume. Each command is presented on a valid/ready command port. The block drives exactly one bus cycle, waits for ACK with a bounded timeout, and returns read data plus an error flag on a valid/ready response port.

---
 rtl/onion_wb_initiator.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/onion_wb_initiator.sv
// onion_wb_initiator
// ------------------
// Turns single register-access commands into one Wishbone bus cycle each,
// toward the FPGA IP slave fabric (GPIO, PWM, breathe, timer, QL-reserved).
// Every command runs one bus cycle, which ends on ACK or on a timeout.
// The result is returned on a valid/ready response port.
//
// Ports
//   WBs_CLK_i, WBs_RST_i     : clock and synchronous active-high reset
//   cmd_*                    : command port (valid/ready)
//                              we, byte address, byte enables, write data
//   rsp_*                    : response port (valid/ready)
//                              read data (0 for writes), timeout error flag
//   WBs_*_o                  : Wishbone initiator outputs
//                              0 whenever no bus cycle is running
//   WBs_RD_DAT_i, WBs_ACK_i  : muxed slave read data and ORed slave ACK
//   err_cnt_o                : saturating count of timed-out cycles
module onion_wb_initiator #(
  parameter int          APERWIDTH          = 17,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          TIMEOUT_WIDTH      = 8,
  parameter logic [31:0] TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,

  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [APERWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_byte_stb_i,
  input  logic [31:0]          cmd_dat_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_dat_o,
  output logic                 rsp_err_o,

  output logic [APERWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic                 WBs_RD_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [31:0]          WBs_WR_DAT_o,
  input  logic [31:0]          WBs_RD_DAT_i,
  input  logic                 WBs_ACK_i,

  output logic [7:0]           err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Last counter value of a cycle that is still allowed to wait for ACK.
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic                   rd_q, rd_d;
  logic [APERWIDTH-1:0]   adr_q, adr_d;
  logic [3:0]             bstb_q, bstb_d;
  logic [31:0]            wdat_q, wdat_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [31:0]            rsp_dat_q, rsp_dat_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  // Next-state and next-output logic. Bus outputs are registered, so they
  // are loaded on the accept edge and cleared on the edge that ends the
  // cycle. This keeps them at zero in IDLE and RESP with no extra gating.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    rd_d      = rd_q;
    adr_d     = adr_q;
    bstb_d    = bstb_q;
    wdat_d    = wdat_q;
    tmo_d     = tmo_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we_i;
          rd_d    = ~cmd_we_i;
          adr_d   = cmd_adr_i;
          // Reads always fetch the whole word, and write data is zero.
          bstb_d  = cmd_we_i ? cmd_byte_stb_i : 4'hF;
          wdat_d  = cmd_we_i ? cmd_dat_i : 32'h0;
          tmo_d   = '0;
        end
      end

      ST_BUS: begin
        // ACK takes priority over the timeout threshold in the same cycle.
        if (WBs_ACK_i || (tmo_q == TMO_LAST)) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rd_d    = 1'b0;
          adr_d   = '0;
          bstb_d  = 4'h0;
          wdat_d  = 32'h0;
          if (WBs_ACK_i) begin
            rsp_dat_d = we_q ? 32'h0 : WBs_RD_DAT_i;
            rsp_err_d = 1'b0;
          end else begin
            rsp_dat_d = we_q ? 32'h0 : TIMEOUT_READ_VALUE;
            rsp_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. A reset drops any in-flight cycle, and no
  // response is produced for it.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      adr_q     <= '0;
      bstb_q    <= 4'h0;
      wdat_q    <= 32'h0;
      tmo_q     <= '0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= 8'h0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      adr_q     <= adr_d;
      bstb_q    <= bstb_d;
      wdat_q    <= wdat_d;
      tmo_q     <= tmo_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;

  assign WBs_ADR_o      = adr_q;
  assign WBs_CYC_o      = cyc_q;
  assign WBs_STB_o      = cyc_q;
  assign WBs_WE_o       = we_q;
  assign WBs_RD_o       = rd_q;
  assign WBs_BYTE_STB_o = bstb_q;
  assign WBs_WR_DAT_o   = wdat_q;

  assign err_cnt_o      = err_cnt_q;

endmodule
